vc_buffer: RTL

Parametrised multi-channel successor to the single-queue router buffer. It holds `num_vc` independent FIFOs (virtual channels) of `buffer_depth` entries each, behind one write port and one read port. Each port is steered by a channel index. Reads are show-ahead. Each channel reports its own full, empty, almost-full and occupancy status. Sticky error flags record overflow and underflow. It sits at router input ports, where head-of-line blocking between traffic classes must be avoided.

---
 rtl/vc_buffer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/vc_buffer.sv
// Multi-channel input buffer: num_vc independent show-ahead FIFOs sharing one
// write port and one read port, each steered by a channel index.
module vc_buffer #(
    parameter int buffer_depth          = 8,
    parameter int buffer_width          = 64,
    parameter int num_vc                = 4,
    parameter int almost_full_threshold = 6,
    localparam int vc_bits = (num_vc > 1) ? $clog2(num_vc) : 1,
    localparam int cnt_w   = $clog2(buffer_depth + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [buffer_width-1:0]   in,
    input  logic [vc_bits-1:0]        in_vc,
    input  logic                      produce,
    input  logic [vc_bits-1:0]        out_vc,
    input  logic                      consume,
    output logic [buffer_width-1:0]   out,
    output logic [num_vc-1:0]         full,
    output logic [num_vc-1:0]         empty,
    output logic [num_vc-1:0]         almost_full,
    output logic [num_vc*cnt_w-1:0]   usedw,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int ptr_w = $clog2(buffer_depth);

    logic [buffer_width-1:0] mem_q [num_vc][buffer_depth];
    logic [ptr_w-1:0]        head_q [num_vc];
    logic [ptr_w-1:0]        head_d [num_vc];
    logic [ptr_w-1:0]        tail_q [num_vc];
    logic [ptr_w-1:0]        tail_d [num_vc];
    logic [cnt_w-1:0]        cnt_q  [num_vc];
    logic [cnt_w-1:0]        cnt_d  [num_vc];
    logic [num_vc-1:0]       wr_en;
    logic [num_vc-1:0]       rd_en;
    logic                    overflow_q, overflow_d;
    logic                    underflow_q, underflow_d;

    function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(buffer_depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Looping over real channels only makes an out-of-range index match nothing,
    // so range checking falls out of the decode for free.
    always_comb begin
        wr_en = '0;
        rd_en = '0;
        for (int v = 0; v < num_vc; v++) begin
            rd_en[v] = consume && (out_vc == vc_bits'(v)) && (cnt_q[v] != '0);
            // A full channel still accepts a write when the same cycle pops it.
            wr_en[v] = produce && (in_vc == vc_bits'(v)) &&
                       ((cnt_q[v] != cnt_w'(buffer_depth)) || rd_en[v]);
        end
    end

    always_comb begin
        for (int v = 0; v < num_vc; v++) begin
            head_d[v] = rd_en[v] ? next_ptr(head_q[v]) : head_q[v];
            tail_d[v] = wr_en[v] ? next_ptr(tail_q[v]) : tail_q[v];
            case ({wr_en[v], rd_en[v]})
                2'b10:   cnt_d[v] = cnt_q[v] + 1'b1;
                2'b01:   cnt_d[v] = cnt_q[v] - 1'b1;
                default: cnt_d[v] = cnt_q[v];
            endcase
        end
        overflow_d  = overflow_q  || (produce && (wr_en == '0));
        underflow_d = underflow_q || (consume && (rd_en == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < num_vc; v++) begin
                head_q[v] <= '0;
                tail_q[v] <= '0;
                cnt_q[v]  <= '0;
            end
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int v = 0; v < num_vc; v++) begin
                head_q[v] <= head_d[v];
                tail_q[v] <= tail_d[v];
                cnt_q[v]  <= cnt_d[v];
            end
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < num_vc; v++) begin
            if (wr_en[v]) begin
                mem_q[v][tail_q[v]] <= in;
            end
        end
    end

    always_comb begin
        out         = '0;
        full        = '0;
        empty       = '0;
        almost_full = '0;
        usedw       = '0;
        for (int v = 0; v < num_vc; v++) begin
            if ((out_vc == vc_bits'(v)) && (cnt_q[v] != '0)) begin
                out = mem_q[v][head_q[v]];
            end
            full[v]                 = (cnt_q[v] == cnt_w'(buffer_depth));
            empty[v]                = (cnt_q[v] == '0);
            almost_full[v]          = (cnt_q[v] >= cnt_w'(almost_full_threshold));
            usedw[v*cnt_w +: cnt_w] = cnt_q[v];
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
